// File: rtl/store_buffer.sv
// In-order store queue sitting between the MEM stage and the data memory
// write port. Stores retire oldest-first, one per cycle, whenever the port
// is not taken by a load. Loads get full-word forwarding from the newest
// matching sw; any other overlap with a pending store stalls the load.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StoreValid,
  output logic              StoreReady,
  input  logic [ADDR_W-1:0] StoreAddr,
  input  logic [DATA_W-1:0] StoreData,
  input  logic [2:0]        StoreFunct3,
  output logic              StoreMisaligned,
  input  logic              LoadValid,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [2:0]        LoadFunct3,
  output logic              LoadHit,
  output logic [DATA_W-1:0] LoadFwdData,
  output logic              LoadStall,
  input  logic              MemBusy,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic [2:0]        MemFunct3,
  output logic              Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;

  logic [ADDR_W-1:0] entry_addr_q [DEPTH];
  logic [DATA_W-1:0] entry_data_q [DEPTH];
  logic [2:0]        entry_f3_q   [DEPTH];

  logic              misaligned;
  logic              enq;
  logic              drain;

  logic [PTR_W-1:0]  scan_idx;
  logic              match_found;
  logic              match_is_sw;
  logic [DATA_W-1:0] match_data;

  // Matching is word-granular, so the load byte offset never participates.
  logic              load_offset_unused;
  assign load_offset_unused = ^LoadAddr[1:0];

  // Handshake, misalignment and drain qualification
  always_comb begin
    misaligned      = ((StoreFunct3 == F3_SH) && StoreAddr[0]) ||
                      ((StoreFunct3 == F3_SW) && (StoreAddr[1:0] != 2'b00));
    StoreReady      = (count_q != FULL_CNT);
    StoreMisaligned = StoreValid & misaligned;
    enq             = StoreValid & StoreReady & ~misaligned;
    drain           = (count_q != '0) & ~MemBusy;
    Empty           = (count_q == '0);
  end

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq)   tail_d = tail_q + 1'b1;
    if (drain) head_d = head_q + 1'b1;
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload capture at the tail slot (payload is not reset)
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_addr_q[tail_q] <= StoreAddr;
      entry_data_q[tail_q] <= StoreData;
      entry_f3_q[tail_q]   <= StoreFunct3;
    end
  end

  // Memory write port driven from the head entry
  always_comb begin
    MemWrite     = drain;
    MemAddress   = '0;
    MemWriteData = '0;
    MemFunct3    = '0;
    if (count_q != '0) begin
      MemAddress   = entry_addr_q[head_q];
      MemWriteData = entry_data_q[head_q];
      MemFunct3    = entry_f3_q[head_q];
    end
  end

  // Load check: walk oldest to newest so the last hit is the newest match;
  // the head entry draining this cycle is still scanned.
  always_comb begin
    scan_idx    = '0;
    match_found = 1'b0;
    match_is_sw = 1'b0;
    match_data  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + k[PTR_W-1:0];
      if ((k[PTR_W:0] < count_q) &&
          (entry_addr_q[scan_idx][ADDR_W-1:2] == LoadAddr[ADDR_W-1:2])) begin
        match_found = 1'b1;
        match_is_sw = (entry_f3_q[scan_idx] == F3_SW);
        match_data  = entry_data_q[scan_idx];
      end
    end
    LoadHit     = LoadValid & match_found & match_is_sw & (LoadFunct3 == F3_SW);
    LoadStall   = LoadValid & match_found & ~(match_is_sw & (LoadFunct3 == F3_SW));
    LoadFwdData = LoadHit ? match_data : '0;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scenario bench for store_buffer: expected memory writes are queued when a
// store handshakes and compared when the DUT strobes MemWrite.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StoreValid;
  logic        StoreReady;
  logic [31:0] StoreAddr;
  logic [31:0] StoreData;
  logic [2:0]  StoreFunct3;
  logic        StoreMisaligned;
  logic        LoadValid;
  logic [31:0] LoadAddr;
  logic [2:0]  LoadFunct3;
  logic        LoadHit;
  logic [31:0] LoadFwdData;
  logic        LoadStall;
  logic        MemBusy;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [2:0]  MemFunct3;
  logic        Empty;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } wr_t;

  wr_t sb_q[$];
  wr_t exp_w;
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .StoreValid(StoreValid), .StoreReady(StoreReady), .StoreAddr(StoreAddr),
    .StoreData(StoreData), .StoreFunct3(StoreFunct3), .StoreMisaligned(StoreMisaligned),
    .LoadValid(LoadValid), .LoadAddr(LoadAddr), .LoadFunct3(LoadFunct3),
    .LoadHit(LoadHit), .LoadFwdData(LoadFwdData), .LoadStall(LoadStall),
    .MemBusy(MemBusy), .MemWrite(MemWrite), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemFunct3(MemFunct3), .Empty(Empty)
  );

  // Scoreboard: every write strobe must match the oldest expected store
  always @(negedge clk) begin
    if (rst_n && MemWrite) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got a=%h d=%h f=%0d, expected no write",
                 MemAddress, MemWriteData, MemFunct3);
      end else begin
        exp_w = sb_q.pop_front();
        if ({MemAddress, MemWriteData, MemFunct3} !== exp_w) begin
          failures++;
          $display("FAIL write_order got a=%h d=%h f=%0d expected a=%h d=%h f=%0d",
                   MemAddress, MemWriteData, MemFunct3, exp_w.a, exp_w.d, exp_w.f);
        end
      end
    end
  end

  // Present a store and hold it until handshaken; called and returns at posedge+1
  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int  n = 0;
    logic mis;
    mis = ((f == 3'b001) && a[0]) || ((f == 3'b010) && (a[1:0] != 2'b00));
    StoreValid = 1'b1; StoreAddr = a; StoreData = d; StoreFunct3 = f;
    @(negedge clk);
    while (!StoreReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!StoreReady) begin
      checks++; failures++;
      $display("FAIL store_ready_timeout got ready=%b expected 1", StoreReady);
    end else if (!mis) begin
      sb_q.push_back('{a: a, d: d, f: f});
    end
    @(posedge clk); #1;
    StoreValid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    MemBusy = 1'b0;
    @(negedge clk);
    while (!Empty && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (Empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_timeout got empty=%b expected 1", Empty);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    StoreValid = 0; StoreAddr = 0; StoreData = 0; StoreFunct3 = 0;
    LoadValid = 0; LoadAddr = 0; LoadFunct3 = 0; MemBusy = 0;
    #1;
    checks++;
    if ({MemWrite, StoreReady, Empty, LoadHit, LoadStall, StoreMisaligned} !== 6'b011000) begin
      failures++;
      $display("FAIL reset_flags got %b expected 011000",
               {MemWrite, StoreReady, Empty, LoadHit, LoadStall, StoreMisaligned});
    end
    checks++;
    if ({LoadFwdData, MemAddress, MemWriteData, MemFunct3} !== '0) begin
      failures++;
      $display("FAIL reset_data got fwd=%h a=%h d=%h f=%0d expected all zero",
               LoadFwdData, MemAddress, MemWriteData, MemFunct3);
    end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_sw();
    put(32'h0000_1000, 32'hDEAD_BEEF, 3'b010);
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b1 || MemAddress !== 32'h1000 || MemWriteData !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_latency got w=%b a=%h d=%h expected w=1 a=00001000 d=deadbeef",
               MemWrite, MemAddress, MemWriteData);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (Empty !== 1'b1 || MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL single_empty got empty=%b w=%b expected empty=1 w=0", Empty, MemWrite);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_wrap();
    bit acc = 0;
    MemBusy = 1'b1;
    for (int i = 0; i < 4; i++) put(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 3'b010);
    StoreValid = 1'b1; StoreAddr = 32'h8000_0000; StoreData = 32'h0000_00FF; StoreFunct3 = 3'b010;
    @(negedge clk);
    checks++;
    if (StoreReady !== 1'b0 || MemWrite !== 1'b0 || Empty !== 1'b0) begin
      failures++;
      $display("FAIL full_ready got ready=%b w=%b empty=%b expected 0 0 0",
               StoreReady, MemWrite, Empty);
    end
    @(posedge clk); #1;
    MemBusy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (MemWrite !== 1'b1) begin
        failures++;
        $display("FAIL drain_consecutive cycle=%0d got w=%b expected 1", i, MemWrite);
      end
      if (i == 0) begin
        checks++;
        if (StoreReady !== 1'b0) begin
          failures++;
          $display("FAIL full_drain_ready got ready=%b expected 0", StoreReady);
        end
      end
      if (!acc && StoreReady) begin
        sb_q.push_back('{a: 32'h8000_0000, d: 32'h0000_00FF, f: 3'b010});
        acc = 1;
      end
      @(posedge clk); #1;
      if (acc) StoreValid = 1'b0;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL fifth_accept got accepted=0 expected 1");
    end
    wait_empty();
  endtask

  task automatic test_forward();
    MemBusy = 1'b1;
    put(32'h2000, 32'h1111_1111, 3'b010);
    put(32'h2000, 32'h2222_2222, 3'b010);
    LoadValid = 1'b1; LoadAddr = 32'h2000; LoadFunct3 = 3'b010;
    @(negedge clk);
    checks++;
    if (LoadHit !== 1'b1 || LoadFwdData !== 32'h2222_2222 || LoadStall !== 1'b0) begin
      failures++;
      $display("FAIL fwd_newest got hit=%b data=%h stall=%b expected 1 22222222 0",
               LoadHit, LoadFwdData, LoadStall);
    end
    @(posedge clk); #1;
    LoadAddr = 32'h2001; LoadFunct3 = 3'b000;
    @(negedge clk);
    checks++;
    if (LoadHit !== 1'b0 || LoadStall !== 1'b1 || LoadFwdData !== 32'h0) begin
      failures++;
      $display("FAIL fwd_lb_stall got hit=%b stall=%b data=%h expected 0 1 0",
               LoadHit, LoadStall, LoadFwdData);
    end
    @(posedge clk); #1;
    LoadValid = 1'b0; LoadFunct3 = 3'b010; LoadAddr = 32'h2000;
    @(negedge clk);
    checks++;
    if (LoadHit !== 1'b0 || LoadStall !== 1'b0 || LoadFwdData !== 32'h0) begin
      failures++;
      $display("FAIL load_idle got hit=%b stall=%b data=%h expected 0 0 0",
               LoadHit, LoadStall, LoadFwdData);
    end
    @(posedge clk); #1;
    wait_empty();
  endtask

  task automatic test_partial();
    MemBusy = 1'b1;
    put(32'h3001, 32'h0000_00AB, 3'b000);
    LoadValid = 1'b1; LoadAddr = 32'h3000; LoadFunct3 = 3'b010;
    @(negedge clk);
    checks++;
    if (LoadStall !== 1'b1 || LoadHit !== 1'b0) begin
      failures++;
      $display("FAIL partial_stall got stall=%b hit=%b expected 1 0", LoadStall, LoadHit);
    end
    @(posedge clk); #1;
    LoadAddr = 32'h3004; LoadFunct3 = 3'b100;
    @(negedge clk);
    checks++;
    if (LoadStall !== 1'b0 || LoadHit !== 1'b0) begin
      failures++;
      $display("FAIL other_word got stall=%b hit=%b expected 0 0", LoadStall, LoadHit);
    end
    @(posedge clk); #1;
    LoadAddr = 32'h3000; LoadFunct3 = 3'b010; MemBusy = 1'b0;
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b1 || LoadStall !== 1'b1) begin
      failures++;
      $display("FAIL draining_head_present got w=%b stall=%b expected 1 1", MemWrite, LoadStall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (LoadStall !== 1'b0 || LoadHit !== 1'b0 || Empty !== 1'b1) begin
      failures++;
      $display("FAIL after_drain got stall=%b hit=%b empty=%b expected 0 0 1",
               LoadStall, LoadHit, Empty);
    end
    @(posedge clk); #1;
    LoadValid = 1'b0;
  endtask

  task automatic test_misaligned();
    StoreValid = 1'b1; StoreAddr = 32'h4002; StoreData = 32'h1234_5678; StoreFunct3 = 3'b010;
    @(negedge clk);
    checks++;
    if (StoreMisaligned !== 1'b1 || StoreReady !== 1'b1) begin
      failures++;
      $display("FAIL sw_misaligned got mis=%b ready=%b expected 1 1", StoreMisaligned, StoreReady);
    end
    @(posedge clk); #1;
    StoreAddr = 32'h4001; StoreFunct3 = 3'b001;
    @(negedge clk);
    checks++;
    if (StoreMisaligned !== 1'b1) begin
      failures++;
      $display("FAIL sh_odd_misaligned got mis=%b expected 1", StoreMisaligned);
    end
    @(posedge clk); #1;
    StoreValid = 1'b0;
    @(negedge clk);
    checks++;
    if (Empty !== 1'b1 || MemWrite !== 1'b0 || StoreMisaligned !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_dropped got empty=%b w=%b mis=%b expected 1 0 0",
               Empty, MemWrite, StoreMisaligned);
    end
    @(posedge clk); #1;
    put(32'h4002, 32'h0000_BEEF, 3'b001);
    wait_empty();
  endtask

  task automatic test_reset_mid_drain();
    MemBusy = 1'b1;
    for (int i = 0; i < 3; i++) put(32'h5000 + 32'(i * 4), 32'h5500_0000 + 32'(i), 3'b010);
    MemBusy = 1'b0;
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_drain got w=%b expected 1", MemWrite);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || Empty !== 1'b1 || StoreReady !== 1'b1 || MemAddress !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got w=%b empty=%b ready=%b a=%h expected 0 1 1 0",
               MemWrite, Empty, StoreReady, MemAddress);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (MemWrite !== 1'b0 || Empty !== 1'b1) begin
        failures++;
        $display("FAIL stale_write cycle=%0d got w=%b empty=%b expected 0 1", i, MemWrite, Empty);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_sw();
    test_fill_wrap();
    test_forward();
    test_partial();
    test_misaligned();
    test_reset_mid_drain();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
